// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing helpers for the memory request controller and its array.
package mem_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RSP_DEPTH_DEF = 4;

  function automatic int aw_of(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Synchronous FIFO with occupancy count; a pop frees a slot for a push in the same cycle.
module mem_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_s     = (count_q == CW'(DEPTH));
  assign pop_ok_s   = pop_i & ~empty_o;
  assign push_ok_s  = push_i & (~full_s | pop_ok_s);
  assign pop_data_o = mem_q[rptr_q];
  assign count_o    = count_q;

  // pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok_s) begin
      wptr_d = ptr_inc(wptr_q);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = ptr_inc(rptr_q);
    end else begin
      rptr_d = rptr_q;
    end
    if (push_ok_s && !pop_ok_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // storage; cleared so the head reads as zero out of reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Request-side controller for a single-port array: valid/ready requests, credit-gated
// reads into a response FIFO, and a zero-fill clear sequencer.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 256,
  parameter int RSP_DEPTH = RSP_DEPTH_DEF,
  localparam int AW       = aw_of(DEPTH),
  localparam int FCW      = $clog2(RSP_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             mem_wr_en,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int KW = FCW + 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             rd_pending_q, rd_pending_d;
  logic             clr_done_q, clr_done_d;
  logic [FCW-1:0]   fifo_count_s;
  logic             rsp_empty_s;
  logic             credit_ok_s;
  logic             clr_last_s;
  logic             ready_s;
  logic             rd_acc_s;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_ok_s = (KW'(fifo_count_s) + KW'(rd_pending_q)) < KW'(RSP_DEPTH);
  assign clr_last_s  = (state_q == ST_CLEAR) && (cnt_q == AW'(DEPTH - 1));
  assign rd_acc_s    = req_valid & ready_s & ~req_we;
  assign req_ready   = ready_s;
  assign rsp_valid   = ~rsp_empty_s;
  assign clr_done    = clr_done_q;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // output logic: handshake and array-side drive
  always_comb begin
    ready_s   = 1'b0;
    clr_busy  = 1'b0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (!clr_start) begin
          ready_s = req_we | credit_ok_s;
        end else begin
          ready_s = 1'b0;
        end
        if (req_valid && ready_s) begin
          mem_wr_en = req_we;
          mem_rd_en = ~req_we;
          mem_addr  = req_addr;
          mem_wdata = req_we ? req_wdata : '0;
        end else begin
          mem_wr_en = 1'b0;
          mem_rd_en = 1'b0;
        end
      end
      ST_CLEAR: begin
        clr_busy  = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // clear counter, pending-read flag and done pulse next-state
  always_comb begin
    cnt_d        = cnt_q;
    rd_pending_d = rd_acc_s;
    clr_done_d   = clr_last_s;
    if ((state_q == ST_IDLE) && clr_start) begin
      cnt_d = '0;
    end else if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + AW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // clear counter, pending-read flag and done pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_pending_q <= rd_pending_d;
      clr_done_q   <= clr_done_d;
    end
  end

  mem_rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push_i      (rd_pending_q),
    .push_data_i (mem_rdata),
    .pop_i       (rsp_ready),
    .pop_data_o  (rsp_data),
    .count_o     (fifo_count_s),
    .empty_o     (rsp_empty_s)
  );

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural array and an in-order response scoreboard.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 256;
  localparam int RSP_DEPTH = 4;
  localparam int AW        = aw_of(DEPTH);

  logic             clk = 1'b0;
  logic             rstn;
  logic             req_valid, req_ready, req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             clr_start, clr_busy, clr_done;
  logic             mem_wr_en, mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata = '0;

  logic [WIDTH-1:0] arr [DEPTH];
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  always #5 clk = ~clk;

  mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // single-port array with registered read data
  always @(posedge clk) begin
    if (mem_wr_en) arr[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= arr[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample at negedge, update model/scoreboard, return 1ns after posedge
  task automatic step(input int chk_rdy, output logic acc);
    @(negedge clk);
    if (chk_rdy >= 0) check("req_ready", req_ready, chk_rdy[0]);
    acc = req_valid & req_ready;
    if (rsp_valid & rsp_ready) begin
      pops++;
      check("rsp_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("rsp_data", rsp_data, exp_q.pop_front());
    end
    if (acc) begin
      if (req_we) ref_mem[req_addr] = req_wdata;
      else exp_q.push_back(ref_mem[req_addr]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    logic a;
    step(-1, a);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    for (int i = 0; i < 20 && !acc; i++) step(-1, acc);
    check("req_accept", acc, 1'b1);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int p0, busy_cnt, done_cnt, done_at;
    logic acc;
    for (int i = 0; i < DEPTH; i++) begin
      arr[i] = '0;
      ref_mem[i] = '0;
    end
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; clr_start = 1'b0;
    #12;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_clr_busy", clr_busy, 1'b0);
    check("rst_clr_done", clr_done, 1'b0);
    check("rst_mem_en", {mem_wr_en, mem_rd_en}, 2'b00);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // read-after-write and 2-cycle latency
    rsp_ready = 1'b1;
    issue(1'b1, 8'h10, 32'hDEADBEEF);
    issue(1'b0, 8'h10, 32'h0);
    check("lat_edge_n", rsp_valid, 1'b0);
    tick();
    check("lat_valid", rsp_valid, 1'b1);
    check("lat_data", rsp_data, 32'hDEADBEEF);
    drain();

    // fill, then back-to-back reads with req_ready never dropping
    for (int k = 0; k < DEPTH; k++) issue(1'b1, AW'(k), WIDTH'(k * 3));
    p0 = pops;
    req_valid = 1'b1; req_we = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      req_addr = AW'(k);
      step(1, acc);
    end
    req_valid = 1'b0;
    drain();
    check("b2b_count", pops - p0, DEPTH);

    // backpressure: credit limit stops at RSP_DEPTH, data held, all six return in order
    rsp_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 4; i++) issue(1'b0, AW'(i), '0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
    for (int i = 0; i < 3; i++) begin
      step(0, acc);
      check("bp_hold", rsp_data, 32'd3);
    end
    check("bp_valid", rsp_valid, 1'b1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, 8'd5, '0);
    issue(1'b0, 8'd6, '0);
    drain();
    check("bp_count", pops - p0, 6);

    // clear wins over a simultaneous write; in-flight read still returns old data
    issue(1'b1, 8'd0, 32'hA5);
    issue(1'b0, 8'd7, '0);
    clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd5; req_wdata = 32'h1234;
    step(0, acc);
    clr_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int j = 0; j < 300 && done_cnt == 0; j++) begin
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        done_at = j;
      end
      clr_start = (j == 100);
      tick();
    end
    clr_start = 1'b0;
    check("clr_busy_cycles", busy_cnt, DEPTH);
    check("clr_done_count", done_cnt, 1);
    check("clr_done_at", done_at, DEPTH);
    check("clr_done_pulse", clr_done, 1'b0);
    check("clr_busy_end", clr_busy, 1'b0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    issue(1'b0, 8'd0, '0);
    issue(1'b0, 8'd127, '0);
    issue(1'b0, 8'd255, '0);
    issue(1'b0, 8'd5, '0);
    drain();

    // reset during clear with two buffered responses
    issue(1'b1, 8'd1, 32'h11);
    issue(1'b1, 8'd2, 32'h22);
    rsp_ready = 1'b0;
    issue(1'b0, 8'd1, '0);
    issue(1'b0, 8'd2, '0);
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_clr_busy", clr_busy, 1'b1);
    check("mid_rsp_valid", rsp_valid, 1'b1);
    #2 rstn = 1'b0;
    #1;
    exp_q.delete();
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_clr_busy", clr_busy, 1'b0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_clr_busy", clr_busy, 1'b0);
    check("post_req_ready", req_ready, 1'b1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("post_no_stale", rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
